// File: rtl/lcd_disp_pkg.sv
// -----------------------------------------------------------------------------
// lcd_disp_pkg
// Shared types and constants for the LCD display-host slot scanner and the
// touch-keypad entry block.
//   state_t       : scan FSM states
//   KEY_CLEAR     : keypad code that clears the entry accumulator
//   KEY_ENTER     : keypad code that publishes the accumulator
//   SLOT_W/NAME_W/VALUE_W : record field widths
// -----------------------------------------------------------------------------
package lcd_disp_pkg;

    localparam int SLOT_W  = 6;
    localparam int NAME_W  = 40;
    localparam int VALUE_W = 32;

    localparam logic [4:0] KEY_CLEAR = 5'h10;
    localparam logic [4:0] KEY_ENTER = 5'h11;

    typedef enum logic [2:0] {
        S_GAP,
        S_REQ,
        S_WAIT,
        S_CAP,
        S_EMIT
    } state_t;

    // Codes 0x00-0x0F are hex digits; everything with bit 4 set is a command.
    function automatic logic is_hex_digit(input logic [4:0] code);
        return (code[4] == 1'b0);
    endfunction

endpackage

// File: rtl/lcd_key_entry.sv
// -----------------------------------------------------------------------------
// lcd_key_entry
// Turns touch-keypad key strobes into an entered 32-bit value.
// Hex digits shift into an 8-nibble accumulator (oldest nibble drops out),
// CLEAR zeroes it, ENTER publishes it with a one-cycle pulse and zeroes it.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   key_valid, key_code  : one-cycle key strobe and its code
//   input_valid          : one-cycle pulse after ENTER
//   input_value          : last entered value, held until the next ENTER
// -----------------------------------------------------------------------------
module lcd_key_entry
    import lcd_disp_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               key_valid,
    input  logic [4:0]         key_code,
    output logic               input_valid,
    output logic [VALUE_W-1:0] input_value
);

    logic [VALUE_W-1:0] acc_q;
    logic [VALUE_W-1:0] input_value_q;
    logic               input_valid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q         <= '0;
            input_value_q <= '0;
            input_valid_q <= 1'b0;
        end else begin
            input_valid_q <= 1'b0;
            if (key_valid) begin
                if (is_hex_digit(key_code)) begin
                    acc_q <= {acc_q[VALUE_W-5:0], key_code[3:0]};
                end else if (key_code == KEY_CLEAR) begin
                    acc_q <= '0;
                end else if (key_code == KEY_ENTER) begin
                    // An empty accumulator still produces a pulse carrying 0.
                    input_value_q <= acc_q;
                    input_valid_q <= 1'b1;
                    acc_q         <= '0;
                end
            end
        end
    end

    assign input_valid = input_valid_q;
    assign input_value = input_value_q;

endmodule

// File: rtl/lcd_disp_host.sv
// -----------------------------------------------------------------------------
// lcd_disp_host
// Panel end of the display/input slot protocol. Walks display_number over
// slots 1..NUM_SLOTS, samples each responder's registered reply and forwards
// populated slots as records on a ready/valid stream. Keypad entry is handled
// by lcd_key_entry.
// Optional build macro: LCD_DIFF_ONLY_EN -- keep a per-slot {valid,value}
// shadow and emit a record only when valid/value changed since last emit.
// Parameters:
//   NUM_SLOTS : highest slot scanned (1..63)
//   FRAME_GAP : idle cycles between scans (>=1)
// Ports:
//   clk, resetn                          : clock, async active-low reset
//   display_number                       : slot requested (0 = none)
//   display_valid/name/value             : responder reply
//   rec_valid/ready, rec_slot/name/value : record stream to renderer
//   key_valid, key_code                  : keypad strobe
//   input_valid, input_value             : entered value pulse / hold
// -----------------------------------------------------------------------------
module lcd_disp_host
    import lcd_disp_pkg::*;
#(
    parameter int NUM_SLOTS = 44,
    parameter int FRAME_GAP = 1000
) (
    input  logic               clk,
    input  logic               resetn,
    output logic [SLOT_W-1:0]  display_number,
    input  logic               display_valid,
    input  logic [NAME_W-1:0]  display_name,
    input  logic [VALUE_W-1:0] display_value,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [SLOT_W-1:0]  rec_slot,
    output logic [NAME_W-1:0]  rec_name,
    output logic [VALUE_W-1:0] rec_value,
    input  logic               key_valid,
    input  logic [4:0]         key_code,
    output logic               input_valid,
    output logic [VALUE_W-1:0] input_value
);

    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FRAME_GAP - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS);

    state_t             state_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [SLOT_W-1:0]  display_number_q;   // doubles as the current slot
    logic               rec_valid_q;
    logic [SLOT_W-1:0]  rec_slot_q;
    logic [NAME_W-1:0]  rec_name_q;
    logic [VALUE_W-1:0] rec_value_q;

    logic               emit_ok;
    logic               last_slot;
    logic [SLOT_W-1:0]  slot_inc;

    assign last_slot = (display_number_q == LAST_SLOT);
    assign slot_inc  = display_number_q + SLOT_W'(1);

`ifdef LCD_DIFF_ONLY_EN
    // Entry 0 is never addressed; indexing by slot number keeps the lookup free
    // of an adder.
    logic [VALUE_W:0] shadow_q [0:NUM_SLOTS];

    assign emit_ok = display_valid &&
                     (shadow_q[display_number_q] != {1'b1, display_value});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= NUM_SLOTS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (state_q == S_CAP) begin
            if (emit_ok) begin
                shadow_q[display_number_q] <= {1'b1, display_value};
            end else if (!display_valid) begin
                // Forget the slot so that its return is reported even with an
                // unchanged value.
                shadow_q[display_number_q] <= '0;
            end
        end
    end
`else
    assign emit_ok = display_valid;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= S_GAP;
            gap_cnt_q        <= '0;
            display_number_q <= '0;
            rec_valid_q      <= 1'b0;
            rec_slot_q       <= '0;
            rec_name_q       <= '0;
            rec_value_q      <= '0;
        end else begin
            case (state_q)
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q        <= '0;
                        display_number_q <= SLOT_W'(1);
                        state_q          <= S_REQ;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                S_REQ:  state_q <= S_WAIT;
                // Responder registers its reply for display_number during WAIT.
                S_WAIT: state_q <= S_CAP;
                S_CAP: begin
                    if (emit_ok) begin
                        rec_valid_q <= 1'b1;
                        rec_slot_q  <= display_number_q;
                        rec_name_q  <= display_name;
                        rec_value_q <= display_value;
                        state_q     <= S_EMIT;
                    end else begin
                        display_number_q <= last_slot ? '0 : slot_inc;
                        state_q          <= last_slot ? S_GAP : S_REQ;
                    end
                end
                S_EMIT: begin
                    // Scan stalls here, display_number held, until accepted.
                    if (rec_ready) begin
                        rec_valid_q      <= 1'b0;
                        display_number_q <= last_slot ? '0 : slot_inc;
                        state_q          <= last_slot ? S_GAP : S_REQ;
                    end
                end
                default: state_q <= S_GAP;
            endcase
        end
    end

    assign display_number = display_number_q;
    assign rec_valid      = rec_valid_q;
    assign rec_slot       = rec_slot_q;
    assign rec_name       = rec_name_q;
    assign rec_value      = rec_value_q;

    lcd_key_entry u_key_entry (
        .clk         (clk),
        .resetn      (resetn),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .input_valid (input_valid),
        .input_value (input_value)
    );

endmodule
